// File: rtl/imm_extend_pipe.sv
// Immediate extraction/extension unit with a single valid/ready output register.
// Optional feature macro: IMM_BRANCH_SCALE_EN (scales CB/B-type immediates by 4).
module imm_extend_pipe #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [2:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm,
    output logic              err,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic [2:0] {
        FMT_D    = 3'd0,
        FMT_I    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_MOVZ = 3'd4
    } fmt_e;

    logic [63:0]       wide;
    logic [63:0]       branch_ext;
    logic [5:0]        movz_shamt;
    logic              dec_err;
    logic [DATA_W-1:0] dec_imm;
    logic              accept;
    logic              unused_bits;

    assign unused_bits = ^instr[31:26];
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign movz_shamt  = {instr[22:21], 4'b0000};

    // Decode at full 64-bit width, then truncate once to DATA_W.
    always_comb begin
        wide       = '0;
        branch_ext = '0;
        dec_err    = 1'b0;
        case (mode)
            FMT_D:    wide = {{55{instr[20]}}, instr[20:12]};
            FMT_I:    wide = {52'b0, instr[21:10]};
            FMT_CB: begin
                branch_ext = {{45{instr[23]}}, instr[23:5]};
`ifdef IMM_BRANCH_SCALE_EN
                wide = branch_ext << 2;
`else
                wide = branch_ext;
`endif
            end
            FMT_B: begin
                branch_ext = {{38{instr[25]}}, instr[25:0]};
`ifdef IMM_BRANCH_SCALE_EN
                wide = branch_ext << 2;
`else
                wide = branch_ext;
`endif
            end
            FMT_MOVZ: wide = {48'b0, instr[20:5]} << movz_shamt;
            default:  dec_err = 1'b1;
        endcase
        dec_imm = wide[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            imm       <= '0;
            err       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            imm       <= dec_imm;
            err       <= dec_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (accept && dec_err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (default DATA_W=64, CNT_W=8).
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [2:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] imm;
    logic        err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

`ifdef IMM_BRANCH_SCALE_EN
    localparam logic [63:0] EXP_B_NEG  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] EXP_B_POS  = 64'h0000_0000_07FF_FFFC;
    localparam logic [63:0] EXP_CB_NEG = 64'hFFFF_FFFF_FFF0_0000;
    localparam logic [63:0] EXP_CB_POS = 64'h0000_0000_0000_0004;
`else
    localparam logic [63:0] EXP_B_NEG  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_B_POS  = 64'h0000_0000_01FF_FFFF;
    localparam logic [63:0] EXP_CB_NEG = 64'hFFFF_FFFF_FFFC_0000;
    localparam logic [63:0] EXP_CB_POS = 64'h0000_0000_0000_0001;
`endif

    imm_extend_pipe #(.DATA_W(64), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one input at the negedge; it is accepted on the next posedge.
    task automatic send(input logic [31:0] i, input logic [2:0] m);
        @(negedge clk);
        instr     = i;
        mode      = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        mode      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", imm, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        @(negedge clk);
        reset = 1'b1;

        // First accept on the first edge after reset release
        send(32'h001F_F000, 3'd0);
        chk("d_neg_valid", 64'(out_valid), 64'd1);
        chk("d_neg_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("d_neg_err", 64'(err), 64'd0);
        send(32'h000F_F000, 3'd0);
        chk("d_pos_imm", imm, 64'h0000_0000_0000_00FF);
        send(32'h003F_FC00, 3'd1);
        chk("i_imm", imm, 64'h0000_0000_0000_0FFF);
        send(32'h0057_DDE0, 3'd4);
        chk("movz_hw2_imm", imm, 64'h0000_BEEF_0000_0000);
        send(32'h0062_4680, 3'd4);
        chk("movz_hw3_imm", imm, 64'h1234_0000_0000_0000);
        send(32'h17FF_FFFF, 3'd3);
        chk("b_neg_imm", imm, EXP_B_NEG);
        send(32'h01FF_FFFF, 3'd3);
        chk("b_pos_imm", imm, EXP_B_POS);
        send(32'h0080_0000, 3'd2);
        chk("cb_neg_imm", imm, EXP_CB_NEG);
        send(32'h0000_0020, 3'd2);
        chk("cb_pos_imm", imm, EXP_CB_POS);
        chk("cb_pos_err", 64'(err), 64'd0);

        // Backpressure: pending result held while a new input waits
        send(32'h003F_FC00, 3'd1);
        out_ready = 1'b0;
        instr     = 32'h000F_F000;
        mode      = 3'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_imm_hold", imm, 64'h0000_0000_0000_0FFF);
            chk("bp_valid_hold", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_new_imm", imm, 64'h0000_0000_0000_00FF);
        chk("bp_new_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Illegal modes
        send(32'hFFFF_FFFF, 3'd5);
        chk("ill5_imm", imm, 64'd0);
        chk("ill5_err", 64'(err), 64'd1);
        chk("ill5_count", 64'(err_count), 64'd1);
        @(negedge clk);
        instr     = 32'h1234_5678;
        mode      = 3'd6;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("sat_count", 64'(err_count), 64'd255);
        chk("sat_err", 64'(err), 64'd1);
        send(32'h0000_0000, 3'd7);
        chk("sat_hold_count", 64'(err_count), 64'd255);
        chk("ill7_err", 64'(err), 64'd1);
        chk("ill7_imm", imm, 64'd0);
        send(32'h003F_FC00, 3'd1);
        chk("legal_after_sat_err", 64'(err), 64'd0);
        chk("legal_after_sat_count", 64'(err_count), 64'd255);

        // Asynchronous reset mid-transfer
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) send(32'h0000_0000, 3'd5);
        chk("pre_rst_count", 64'(err_count), 64'd4);
        send(32'h001F_F000, 3'd0);
        out_ready = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_imm", imm, 64'd0);
        chk("async_rst_err", 64'(err), 64'd0);
        chk("async_rst_count", 64'(err_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        send(32'h003F_FC00, 3'd1);
        chk("post_rst_imm", imm, 64'h0000_0000_0000_0FFF);
        chk("post_rst_valid", 64'(out_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate-extraction and extension unit for the 64-bit ARM-subset datapath. It takes a raw 32-bit instruction and a format select, pulls out the immediate field, and sign- or zero-extends it to DATA_W bits. Branch formats are optionally scaled by 4. The result is presented through a valid/ready output register between decode and the ALU/branch-address stage. Illegal format selects are flagged and counted.

## Interface
Parameters:
- DATA_W, 64, output immediate width; legal range 32..64.
- CNT_W, 8, width of the saturating illegal-format counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  instr/mode valid this cycle.
- in_ready  output  1  unit can accept a new input.
- instr  input  32  raw instruction word.
- mode  input  3  immediate format select.
- out_valid  output  1  imm/err hold a result.
- out_ready  input  1  consumer accepts the result.
- imm  output  DATA_W  extended immediate.
- err  output  1  result came from an illegal mode.
- err_count  output  CNT_W  saturating count of accepted illegal-mode inputs.

## Operation
Format decode on the accepted input:
- mode 0, D-type: instr[20:12], 9 bits, sign-extended.
- mode 1, I-type: instr[21:10], 12 bits, zero-extended.
- mode 2, CB-type: instr[23:5], 19 bits, sign-extended, branch-scaled.
- mode 3, B-type: instr[25:0], 26 bits, sign-extended, branch-scaled.
- mode 4, MOVZ: instr[20:5], 16 bits, zero-extended, then shifted left by 16×instr[22:21]. Bits at or above DATA_W are discarded.
- modes 5–7: imm = 0, err = 1.

Extension and width rules:
- Sign extension replicates the field MSB into every bit from the field width up to DATA_W-1.
- Branch scaling is applied after extension, as a left shift with zero fill. The result is truncated to DATA_W.

Handshake, one output register:
- in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready. On accept, imm/err load the decoded result and out_valid is set to 1.
- out_valid && out_ready with no accept clears out_valid. Accept and drain in the same cycle gives back-to-back results.
- While out_valid && !out_ready, imm/err/out_valid hold stable.

Error counter:
- err_count increments on each accepted illegal-mode input.
- It saturates at 2^CNT_W−1 and never wraps.

Reset values:
- out_valid = 0, imm = 0, err = 0, err_count = 0.
- in_ready = 1, which follows from out_valid = 0.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 result per cycle when out_ready stays high.
- Reset asserted mid-transfer clears all state immediately, without waiting for clk. A pending result is dropped.
- The first accept is possible on the first rising edge after reset deasserts.
- in_valid while in_ready = 0 is not an accept. The source must hold instr/mode stable until accepted.
- Counter at saturation plus an illegal accept leaves err_count unchanged. err is still set to 1.

## Configuration
- Macro: IMM_BRANCH_SCALE_EN.
- Defined: modes 2 and 3 are shifted left by 2 after extension (word offset to byte offset).
- Undefined: modes 2 and 3 output the plain extended field. All other modes are unaffected either way.

## Test plan
- Reset and D-type: after reset, out_valid = 0, err_count = 0, in_ready = 1. Then instr = 0x001FF000, mode 0 → next cycle out_valid = 1, imm = 0xFFFF_FFFF_FFFF_FFFF, err = 0.
- I-type and MOVZ: instr = 0x003FFC00, mode 1 → imm = 0x0000_0000_0000_0FFF. Then instr = 0x0057DDE0, mode 4 → imm = 0x0000_BEEF_0000_0000 (0 when DATA_W = 32).
- B-type scaling: instr = 0x17FFFFFF, mode 3 → imm = 0xFFFF_FFFF_FFFF_FFFC with IMM_BRANCH_SCALE_EN, 0xFFFF_FFFF_FFFF_FFFF without it.
- Backpressure: result pending and out_ready = 0 for 3 cycles while a new input is offered → imm/out_valid stable, in_ready = 0, no accept. When out_ready = 1, the new input is accepted the same cycle and appears the next cycle.
- Illegal mode: mode 5 → imm = 0, err = 1, err_count + 1. Then 300 consecutive mode-6 accepts with CNT_W = 8 → err_count = 255.
- Reset mid-transfer: with out_valid = 1 and err_count = 4, drive reset low between edges → out_valid, imm, err, err_count are 0 before the next edge.
